// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage, instruction memory and the control decoder.
// The fetch unit takes the master side; memory and decoder models take the slave side.
`timescale 1ns/1ps
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_sel;
    logic [31:0] br_target;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output instr, instr_pc, instr_pc4, instr_valid,
        input  instr_ready, pc_sel, br_target,
        output fetch_fault
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  instr, instr_pc, instr_pc4, instr_valid,
        output instr_ready, pc_sel, br_target,
        input  fetch_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// KLP32 instruction fetch stage: one outstanding word read, valid/ready hand-off to decode.
// Optional FETCH_MISALIGN_TRAP_EN turns misaligned redirect targets into a sticky TRAP.
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        kill, kill_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] ipc_q, ipc_n;
    logic [31:0] ipc4_q, ipc4_n;
    logic        valid_q, valid_n;
    logic        req;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_q, fault_n;
    logic        misaligned;

    assign misaligned = |bus.br_target[1:0];
`endif

    assign redirect    = bus.pc_sel && (state != TRAP);
    assign redirect_pc = bus.br_target & ~32'h3;
    assign req         = !rst && (state == FETCH) && !bus.pc_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            kill    <= 1'b0;
            instr_q <= 32'h0;
            ipc_q   <= 32'h0;
            ipc4_q  <= 32'h0;
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            kill    <= kill_n;
            instr_q <= instr_n;
            ipc_q   <= ipc_n;
            ipc4_q  <= ipc4_n;
            valid_q <= valid_n;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q <= fault_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        instr_n = instr_q;
        ipc_n   = ipc_q;
        ipc4_n  = ipc4_q;
        valid_n = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_n = fault_q;
`endif

        case (state)
            FETCH: begin
                if (req && bus.imem_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    if (!kill && !bus.pc_sel) begin
                        instr_n = bus.imem_rdata;
                        ipc_n   = pc;
                        ipc4_n  = pc + 32'd4;
                        valid_n = 1'b1;
                        state_n = HOLD;
                    end else begin
                        kill_n  = 1'b0;
                        state_n = FETCH;
                    end
                end else if (bus.pc_sel) begin
                    // Response still in flight: remember to drop it when it lands.
                    kill_n = 1'b1;
                end
            end
            HOLD: begin
                if (valid_q && bus.instr_ready) begin
                    pc_n    = pc + 32'd4;
                    valid_n = 1'b0;
                    state_n = FETCH;
                end
            end
            TRAP: begin
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        // A redirect overrides whatever the state handling chose for pc/valid.
        if (redirect) begin
            valid_n = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
                state_n = TRAP;
                fault_n = 1'b1;
                kill_n  = 1'b0;
            end else
`endif
            begin
                pc_n = redirect_pc;
                if (state == HOLD) begin
                    state_n = FETCH;
                end
            end
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_pc4   = ipc4_q;
    assign bus.instr_valid = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios, then randomized traffic
// checked against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory responder state (environment, follows what the DUT actually issued).
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          mem_lat;
    int          stray_mode;

    // Reference model: what the fetch stream should look like.
    logic        m_inflight, m_stale, m_valid, m_trap;
    logic [31:0] m_addr, m_next, m_ipc;

    logic        s_req, s_valid, s_fault;
    logic [31:0] s_addr, s_instr, s_ipc, s_ipc4;

    logic [31:0] acc_q[$];
    logic [31:0] cons_q[$];
    logic [31:0] cons4_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        m_inflight = 1'b0;
        m_stale    = 1'b0;
        m_valid    = 1'b0;
        m_trap     = 1'b0;
        m_addr     = 32'h0;
        m_ipc      = 32'h0;
        m_next     = RESET_PC;
        pend       = 1'b0;
        pend_cnt   = 0;
        pend_addr  = 32'h0;
    endtask

    task automatic checkModel(input logic sel);
        logic exp_req;
        exp_req = !m_trap && !m_inflight && !m_valid && !sel;
        checkOutput("imem_req", s_req, exp_req);
        if (exp_req) checkOutput("imem_addr", s_addr, m_next);
        checkOutput("instr_valid", s_valid, m_valid);
        if (m_valid) begin
            checkOutput("instr", s_instr, mem_word(m_ipc));
            checkOutput("instr_pc", s_ipc, m_ipc);
            checkOutput("instr_pc4", s_ipc4, m_ipc + 32'd4);
        end
        checkOutput("fetch_fault", s_fault, m_trap);
    endtask

    // One clock cycle: drive inputs, sample before the edge, check, advance model.
    task automatic applyStimulus(input logic rdy, input logic irdy, input logic sel, input logic [31:0] tgt);
        logic rv, m_fire, m_acc;
        bus.imem_ready  = rdy;
        bus.instr_ready = irdy;
        bus.pc_sel      = sel;
        bus.br_target   = tgt;
        rv = pend && (pend_cnt == 0);
        if (!pend && stray_mode == 1) rv = ($urandom_range(0, 7) == 0);
        if (!pend && stray_mode == 2) rv = 1'b1;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = (pend && rv) ? mem_word(pend_addr) : $urandom();
        #1;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.instr_valid;
        s_instr = bus.instr;
        s_ipc   = bus.instr_pc;
        s_ipc4  = bus.instr_pc4;
        s_fault = bus.fetch_fault;
        checkModel(sel);

        if (s_req && rdy) acc_q.push_back(s_addr);
        if (s_valid && irdy) begin
            cons_q.push_back(s_ipc);
            cons4_q.push_back(s_ipc4);
        end

        m_fire = m_valid && irdy;
        m_acc  = !m_trap && !m_inflight && !m_valid && !sel && rdy;
        if (!m_trap) begin
            if (m_fire) begin
                m_valid = 1'b0;
                m_next  = m_ipc + 32'd4;
            end
            if (rv && m_inflight) begin
                if (!m_stale && !sel) begin
                    m_valid = 1'b1;
                    m_ipc   = m_addr;
                end
                m_inflight = 1'b0;
                m_stale    = 1'b0;
            end
            if (m_acc) begin
                m_inflight = 1'b1;
                m_addr     = m_next;
                m_stale    = 1'b0;
            end
            if (sel) begin
                m_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (tgt[1:0] != 2'b00) m_trap = 1'b1; else
`endif
                begin
                    m_next = {tgt[31:2], 2'b00};
                    if (m_inflight) m_stale = 1'b1;
                end
            end
        end

        if (rv && pend) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (s_req && rdy) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            pend_cnt  = (mem_lat > 0 ? mem_lat : int'($urandom_range(1, 3))) - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        bus.pc_sel      = 1'b0;
        bus.br_target   = 32'h0;
        @(posedge clk);
        #1;
        checkOutput("rst_imem_req", bus.imem_req, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst_imem_req2", bus.imem_req, 1'b0);
        checkOutput("rst_instr_valid", bus.instr_valid, 1'b0);
        checkOutput("rst_instr", bus.instr, 32'h0);
        checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
        checkOutput("rst_instr_pc4", bus.instr_pc4, 32'h0);
        checkOutput("rst_fetch_fault", bus.fetch_fault, 1'b0);
        checkOutput("rst_imem_addr", bus.imem_addr, RESET_PC);
        rst = 1'b0;
        resetModel();
    endtask

    task automatic runUntilConsumed(input int max, input string tag);
        int n0, k;
        n0 = cons_q.size();
        k = 0;
        while (cons_q.size() == n0 && k < max) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            k++;
        end
        checkOutput(tag, 32'(cons_q.size() > n0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the test sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        r_sel;
        logic [31:0] r_tgt;
        stray_mode = 0;
        mem_lat    = 1;
        resetModel();
        doReset();

        // Back-to-back fetch with a 1-cycle memory: one instruction every 3 cycles.
        acc_q.delete(); cons_q.delete(); cons4_q.delete();
        repeat (9) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("seq_req_count", acc_q.size(), 3);
        checkOutput("seq_cons_count", cons_q.size(), 3);
        checkOutput("seq_req0", acc_q[0], 32'h0);
        checkOutput("seq_req1", acc_q[1], 32'h4);
        checkOutput("seq_req2", acc_q[2], 32'h8);
        checkOutput("seq_pc0", cons_q[0], 32'h0);
        checkOutput("seq_pc1", cons_q[1], 32'h4);
        checkOutput("seq_pc2", cons_q[2], 32'h8);
        checkOutput("seq_pc4_0", cons4_q[0], 32'h4);

        // Memory back-pressure: request held with a stable address.
        acc_q.delete();
        repeat (3) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("stall_req", s_req, 1'b1);
            checkOutput("stall_addr", s_addr, 32'hC);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_req4", s_req, 1'b1);
        checkOutput("stall_addr4", s_addr, 32'hC);
        checkOutput("stall_xfers", acc_q.size(), 1);

        // Decoder back-pressure: instruction held, no new request.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (5) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("hold_valid", s_valid, 1'b1);
            checkOutput("hold_instr", s_instr, mem_word(32'hC));
            checkOutput("hold_pc", s_ipc, 32'hC);
            checkOutput("hold_req", s_req, 1'b0);
        end
        checkOutput("hold_xfers", acc_q.size(), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        mem_lat = 2;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("after_hold_req", s_req, 1'b1);
        checkOutput("after_hold_addr", s_addr, 32'h10);

        // Redirect while the read is in flight: the returning word must be dropped.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("kill_valid", s_valid, 1'b0);
        checkOutput("kill_req", s_req, 1'b1);
        checkOutput("kill_addr", s_addr, 32'h100);
        cons_q.delete(); cons4_q.delete();
        runUntilConsumed(10, "kill_consume_timeout");
        checkOutput("kill_next_pc", cons_q[cons_q.size()-1], 32'h100);

        // PC wrap at the top of the address space.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        runUntilConsumed(10, "wrap_consume_timeout");
        checkOutput("wrap_pc", cons_q[cons_q.size()-1], 32'hFFFF_FFFC);
        checkOutput("wrap_pc4", cons4_q[cons4_q.size()-1], 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_req", s_req, 1'b1);
        checkOutput("wrap_addr", s_addr, 32'h0);
        runUntilConsumed(10, "wrap2_consume_timeout");

        // Misaligned redirect target.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, (i % 2) == 0, 32'h200);
            checkOutput("trap_fault", s_fault, 1'b1);
            checkOutput("trap_req", s_req, 1'b0);
            checkOutput("trap_valid", s_valid, 1'b0);
        end
`else
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("misalign_req", s_req, 1'b1);
        checkOutput("misalign_addr", s_addr, 32'h100);
        checkOutput("misalign_fault", s_fault, 1'b0);
`endif

        // Reset while a read is pending; a late rvalid in FETCH must be ignored.
        doReset();
        mem_lat = 3;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        doReset();
        stray_mode = 2;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("stray_valid", s_valid, 1'b0);
        checkOutput("stray_req", s_req, 1'b1);
        checkOutput("stray_addr", s_addr, RESET_PC);

        // Randomized traffic against the model.
        stray_mode = 1;
        mem_lat    = 0;
        for (int i = 0; i < 600; i++) begin
            r_sel = ($urandom_range(0, 9) == 0);
            r_tgt = $urandom();
            if ($urandom_range(0, 7) == 0) r_tgt = 32'hFFFF_FFF8;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_tgt[1:0] = 2'b00;
`endif
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, r_sel, r_tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the KLP32 RISC-V core: owns the program counter, issues one word-aligned read at a time to instruction memory, and presents each fetched instruction with its PC to the control decoder through a valid/ready handshake. It is the producer of `instr` and the consumer of `pc_sel` and the branch/jump target, which closes the loop with the control unit.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word-aligned read address, equal to `pc` while `imem_req`=1.
- `imem_ready`  in  1  memory accepts the request in the cycle where `imem_req`=1 and `imem_ready`=1.
- `imem_rvalid`  in  1  read data valid, at least 1 cycle after acceptance.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  instruction presented to the decoder.
- `instr_pc`  out  32  PC of `instr`.
- `instr_pc4`  out  32  `instr_pc + 4`, for the JAL/JALR write-back.
- `instr_valid`  out  1  `instr`, `instr_pc` and `instr_pc4` are valid.
- `instr_ready`  in  1  decoder consumes the instruction this cycle.
- `pc_sel`  in  1  redirect request (taken branch, JAL, or JALR).
- `br_target`  in  32  redirect target, sampled when `pc_sel`=1.
- `fetch_fault`  out  1  sticky misaligned-target fault (see Configuration).

## Operation
- States: FETCH, WAIT, HOLD, TRAP. Internal registers: `pc[31:0]` and a `kill` flag.
- `imem_req = (state==FETCH) && !pc_sel`. `imem_addr = pc`.
- FETCH: on `imem_req && imem_ready`, go to WAIT. Otherwise stay in FETCH with the request held and `pc` stable.
- WAIT: on `imem_rvalid`:
  - If `kill`=0 and `pc_sel`=0: capture `imem_rdata` into `instr`, load `instr_pc`=pc and `instr_pc4`=pc+4, set `instr_valid`=1, go to HOLD.
  - Otherwise: discard the data, clear `kill`, go to FETCH.
- HOLD: when `instr_valid && instr_ready`, set `pc <= pc+4` (mod 2^32, wraps from 32'hFFFF_FFFC to 0), clear `instr_valid`, go to FETCH.
- Redirect (`pc_sel`=1) in any state except TRAP:
  - `pc <= br_target` and `instr_valid <= 0`; the redirect wins over the pc+4 update.
  - In FETCH, no request is issued that cycle and the state stays FETCH.
  - In WAIT without `imem_rvalid`, set `kill`=1 and stay in WAIT.
  - In HOLD, go to FETCH.
- Only one request is outstanding at a time. `imem_rvalid` outside WAIT is ignored.

## Timing
- Reset values: `pc`=RESET_PC, state=FETCH, `kill`=0, `instr`=0, `instr_pc`=0, `instr_pc4`=0, `instr_valid`=0, `fetch_fault`=0. `imem_req` is 0 while `rst`=1.
- First request goes out in the first cycle after `rst` deasserts, with `imem_addr`=RESET_PC.
- Latency: `instr_valid` rises 1 cycle after the accepted `imem_rvalid` edge. The next request can issue 1 cycle after the handshake. Best case with 1-cycle memory: one instruction per 3 cycles.
- A redirect takes effect on the next edge. The first request to the target issues in the cycle after `pc_sel` (from FETCH or HOLD), or the cycle after the killed response (from WAIT).
- Reset mid-WAIT: the state is reset and the pending response is ignored. Memory must drop or flush it; `imem_rvalid` arriving in FETCH is ignored.
- `instr`, `instr_pc` and `instr_pc4` are stable while `instr_valid`=1 and `instr_ready`=0.

## Configuration
- Macro `FETCH_MISALIGN_TRAP_EN`.
- Defined: a redirect with `br_target[1:0]`≠0 enters TRAP instead of updating `pc`.
  - `fetch_fault` goes to 1 on the next edge and is sticky.
  - `imem_req`=0 and `instr_valid`=0 in TRAP; further `pc_sel` is ignored.
  - Only `rst` exits TRAP.
- Undefined: `pc <= {br_target[31:2],2'b00}`, TRAP is unreachable, and `fetch_fault` is tied to 0.

## Test plan
- Reset, then memory with 1-cycle rvalid, `instr_ready`=1 → requests at 0x0, 0x4, 0x8; `instr_pc` sequence 0x0, 0x4, 0x8; `instr_pc4`=0x4 for the first instruction.
- `imem_ready` held low for 3 cycles in FETCH → `imem_req`=1 with `imem_addr` stable for 4 cycles, and exactly one transfer.
- `instr_ready`=0 for 5 cycles in HOLD → `instr`/`instr_pc` unchanged and no new request; after ready, next `imem_addr` = `instr_pc`+4.
- `pc_sel`=1, `br_target`=0x100 while in WAIT → the returning word is dropped (no `instr_valid`), next `imem_addr`=0x100, and the next `instr_pc`=0x100.
- PC at 0xFFFF_FFFC, consumed → next `imem_addr`=0x0000_0000.
- Redirect to 0x102: with `FETCH_MISALIGN_TRAP_EN`, `fetch_fault`=1 and no further `imem_req` until `rst`; without it, next `imem_addr`=0x100.
